// File: rtl/multiplier_datapath.sv
// Register/arithmetic datapath of the 8-bit signed add-shift multiplier.
// Holds A, X, B and the iteration counter; executes controller commands.
module multiplier_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             ClearAX_LoadB,
  input  logic             Ld_A,
  input  logic             Sub,
  input  logic             Shift_En,
  input  logic             CntEn,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             M,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             x;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // 9-bit sign-extended add/sub keeps the signed result exact
  assign sum  = {a[WIDTH-1], a} + {S[WIDTH-1], S};
  assign diff = {a[WIDTH-1], a} + ~{S[WIDTH-1], S}
              + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a   <= '0;
      b   <= '0;
      x   <= 1'b0;
      cnt <= '0;
    end else if (ClearAX_LoadB) begin
      a   <= '0;
      b   <= S;
      x   <= 1'b0;
      cnt <= '0;
    end else begin
      if (Sub) begin
        {x, a} <= diff;
      end else if (Ld_A) begin
        {x, a} <= sum;
      end else if (Shift_En) begin
        a <= {x, a[WIDTH-1:1]};
        b <= {a[0], b[WIDTH-1:1]};
      end
      if (CntEn) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign Aval  = a;
  assign Bval  = b;
  assign X     = x;
  assign M     = b[0];
  assign count = cnt;

endmodule

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
- Register/arithmetic datapath of the 8-bit signed add-shift multiplier. It sits directly downstream of the multiplier control FSM and executes its one-hot-per-cycle commands: clear/load, add, subtract, shift and count.
- Holds accumulator A, sign-extension bit X, multiplier register B and the iteration counter.
- Feeds M (B[0]) and count back to the controller.
- The product is {Aval, Bval} once 8 iterations have completed.

Parameters:
WIDTH, 8, operand width of A, B and S.
CNT_W, 3, counter width; must equal log2(WIDTH).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
S  input  WIDTH  operand switches: multiplier on load, multiplicand on add/sub
ClearAX_LoadB  input  1  clear A, X and count; load B from S
Ld_A  input  1  {X,A} <= A + S (signed)
Sub  input  1  {X,A} <= A - S (signed)
Shift_En  input  1  arithmetic right shift of {X,A,B}
CntEn  input  1  increment iteration counter
Aval  output  WIDTH  A register (product high half)
Bval  output  WIDTH  B register (product low half)
X  output  1  sign-extension bit
M  output  1  B[0], combinational from B register
count  output  CNT_W  iteration counter

Behaviour:
- All state (A, B, X, count) is registered on posedge Clk. Updates are visible one cycle after the command is asserted.
- Reset (sync, highest priority): A=0, B=0, X=0, count=0. Therefore M=0.
- Register update priority, highest first: Reset > ClearAX_LoadB > Sub > Ld_A > Shift_En. Only the highest-priority active command updates A/X/B.
- ClearAX_LoadB: A<=0, X<=0, B<=S, count<=0. Any CntEn in the same cycle is ignored.
- Ld_A: 9-bit sum {A[7],A} + {S[7],S}. X<=sum[8], A<=sum[7:0]. B unchanged.
- Sub: 9-bit sum {A[7],A} + ~{S[7],S} + 1. X<=sum[8], A<=sum[7:0]. B unchanged.
- Ld_A and Sub together: Sub wins.
- Shift_En: X<=X; A<={X,A[WIDTH-1:1]}; B<={A[0],B[WIDTH-1:1]}.
- Ld_A/Sub together with Shift_En: only the add/sub executes; the shift is dropped. The controller never issues this combination; it is defined for determinism only.
- CntEn: count<=count+1 modulo 2^CNT_W, so 7 wraps to 0. CntEn is independent of the A/X/B command, except that ClearAX_LoadB and Reset override it.
- No command active: all registers hold.
- Arithmetic overflow is not flagged. The 9-bit {X,A} sum is exact for 8-bit signed operands.
- Reset asserted mid-multiply: all registers clear on that edge. No partial state survives.

Test Plan:
- Reset with arbitrary prior state -> next cycle Aval=00, Bval=00, X=0, M=0, count=0.
- S=0x03, ClearAX_LoadB for 1 cycle -> Bval=03, M=1, Aval=00, count=0. Then S=0x05, Ld_A -> Aval=05, X=0. Then Shift_En -> Aval=02, Bval=81, X=0.
- From A=00, X=0: S=0x80, Ld_A -> X=1, Aval=80. Then Shift_En -> Aval=C0, X=1. Then S=0xFF, Sub -> Aval=C1, X=1.
- Full multiply, load B=0xFD (-3), multiplicand S=0x07. Repeat 8 iterations: issue Ld_A if M=1 (Sub instead on iteration 8), then Shift_En+CntEn. Expect {Aval,Bval}=FFEB (-21) and count=0 after wrap.
- ClearAX_LoadB + Shift_En + CntEn in the same cycle with S=0x5A -> Bval=5A, Aval=00, count=0.
- 8 consecutive CntEn pulses -> count sequence 1..7, then 0. Reset at count=4 during a Shift_En cycle -> all registers 0 on that edge.
